mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit that sits directly downstream of the general-purpose register file.
- Consumes the file's two 16-bit read ports (A, B) for MULT/MULTU/DIV/DIVU.
- Holds the 32-bit result in internal HI/LO registers; write-back selects from these into the register file's write-data port C.
- Radix-2 shift-add / restoring-divide datapath: one bit per clock; start/busy/done handshake with the control unit.

Parameters:
WIDTH, 16, operand width; HI and LO are each WIDTH bits.

Ports:
clk  input  1  rising-edge clock.
clear  input  1  asynchronous reset, active-low (0 = reset).
start  input  1  launch request; sampled only while busy=0.
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
a  input  WIDTH  operand from register-file port A (multiplicand / dividend).
b  input  WIDTH  operand from register-file port B (multiplier / divisor).
busy  output  1  operation in flight.
done  output  1  one-cycle pulse: HI/LO just updated.
div_zero  output  1  last completed op was a divide with b=0.
hi  output  WIDTH  product[31:16] or remainder.
lo  output  WIDTH  product[15:0] or quotient.

Behaviour:
- Reset (clear=0, asynchronous):
  - Outputs: busy=0, done=0, div_zero=0, hi=0, lo=0.
  - FSM goes to IDLE; iteration counter cleared.
  - An in-flight operation is aborted; no done is produced.
  - Unit is ready at the first edge after clear returns high.
- FSM states:
  - IDLE:
    - start=1 at edge E0: capture op and a, b; compute magnitudes (signed ops: two's-complement abs, zero-extended to WIDTH+1 bits); record result signs; busy=1.
    - Divide with b=0 goes to ZDIV; all other ops go to CALC with count=WIDTH-1.
  - CALC: one iteration per edge for WIDTH edges (E1..E16).
    - Multiply: if multiplier LSB=1, add multiplicand into the upper accumulator (WIDTH+1 bits, carry kept); shift the accumulator pair right by 1.
    - Divide: shift the {rem, quot} pair left by 1; trial-subtract |b| from rem (WIDTH+1 bits); if the result is non-negative, keep it and set quot LSB=1, else restore.
    - Leave for FIX when count=0.
  - FIX (edge E17):
    - Apply sign correction: product is negated if signs differ; quotient is negated if signs differ; remainder takes the dividend's sign.
    - Load hi/lo; div_zero=0; done=1 for exactly one cycle; busy=0; return to IDLE.
  - ZDIV (edge E1): hi=a (raw), lo={WIDTH{1}}, div_zero=1, done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - Normal ops: hi/lo/done update at edge E0+WIDTH+1 (17 for WIDTH=16).
  - Divide by zero: E0+1.
  - Back-to-back: start may be asserted in the done cycle and is accepted (busy=0 then).
- start while busy=1 is ignored; op, a and b changes during busy have no effect.
- hi/lo/div_zero hold their values until the next completion or reset; done is 0 at all other times.
- Arithmetic rules:
  - Signed divide truncates toward zero.
  - Signed 0x8000 / 0xFFFF gives lo=0x8000, hi=0x0000 (wraps, no trap).
  - Signed 0x8000 * 0x8000 gives 0x40000000.
- Unsigned ops ignore all sign handling.
- Internal widths: accumulator WIDTH+1; counter ceil(log2(WIDTH)) bits.

Test Plan:
- MULTU a=0xFFFF b=0xFFFF -> at E17: hi=0xFFFE, lo=0x0001, done pulse 1 cycle, busy 1 during E0..E16.
- MULT a=0xFFFE(-2) b=0x0003 -> hi=0xFFFF, lo=0xFFFA; MULT 0x8000*0x8000 -> hi=0x4000, lo=0x0000.
- DIVU a=100 b=7 -> lo=0x000E, hi=0x0002; DIV a=0xFFF9(-7) b=2 -> lo=0xFFFD, hi=0xFFFF; DIV 0x8000/0xFFFF -> lo=0x8000, hi=0x0000.
- DIV a=0x1234 b=0 -> at E1: div_zero=1, lo=0xFFFF, hi=0x1234, done 1 cycle; a following MULTU 2*3 clears div_zero, lo=6.
- start re-pulsed at E5 with different operands during a MULTU -> ignored, original result at E17; start held in the done cycle -> second op accepted, completes 17 edges later.
- clear driven low mid-CALC (after E8) -> busy, done, hi, lo all 0 immediately, no done afterwards; a new start after release completes normally.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit fed by the register-file read ports.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
// The 32-bit result is held in HI/LO until the next completion or reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands and signs captured on acceptance
// CALC  | one multiply/divide iteration per edge, WIDTH edges in total
// FIX   | sign correction, HI/LO load, one-cycle done pulse
// ZDIV  | divide by zero: HI=a, LO=all ones, div_zero set, done pulse
module mdu_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_ZDIV = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             neg_res;   // product / quotient must be negated
   logic             neg_rem;   // remainder takes the dividend's sign
   logic [WIDTH:0]   acc;       // product high half (carry kept) or partial remainder
   logic [WIDTH:0]   opnd;      // |multiplicand| or |divisor|
   logic [WIDTH-1:0] lsr;       // multiplier / quotient shift register; raw a for ZDIV

   logic accept, iter, load_res, load_zdiv;

   logic             a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] mag_a, mag_b;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     mul_acc;
   logic [WIDTH-1:0]   mul_lsr;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   diff;
   logic               ge;
   logic [WIDTH:0]     div_acc;
   logic [WIDTH-1:0]   div_lsr;

   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   q_fix, r_fix, res_hi, res_lo;

   // operand magnitudes; unsigned ops never negate
   always_comb begin
      a_neg  = op[0] & a[WIDTH-1];
      b_neg  = op[0] & b[WIDTH-1];
      b_zero = (b == '0);
      mag_a  = a_neg ? (~a) + WIDTH'(1) : a;
      mag_b  = b_neg ? (~b) + WIDTH'(1) : b;
   end

   // single iteration step for both multiply and divide
   always_comb begin
      mul_sum = acc + (lsr[0] ? opnd : '0);
      mul_acc = {1'b0, mul_sum[WIDTH:1]};
      mul_lsr = {mul_sum[0], lsr[WIDTH-1:1]};

      rem_sh  = {acc[WIDTH-1:0], lsr[WIDTH-1]};
      diff    = {1'b0, rem_sh} - {1'b0, opnd};
      ge      = ~diff[WIDTH+1];
      div_acc = ge ? diff[WIDTH:0] : rem_sh;
      div_lsr = {lsr[WIDTH-2:0], ge};
   end

   // sign correction applied in FIX
   always_comb begin
      prod     = {acc[WIDTH-1:0], lsr};
      prod_fix = neg_res ? -prod : prod;
      q_fix    = neg_res ? -lsr : lsr;
      r_fix    = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];
   end

   // state register
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = (op[1] && b_zero) ? S_ZDIV : S_CALC;
         S_CALC: if (cnt == '0) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_IDLE;
         S_ZDIV: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // state-decoded controls
   always_comb begin
      busy      = (state != S_IDLE);
      accept    = (state == S_IDLE) && start;
      iter      = (state == S_CALC);
      load_res  = (state == S_FIX);
      load_zdiv = (state == S_ZDIV);
   end

   // operand capture and iteration datapath
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         acc     <= '0;
         opnd    <= '0;
         lsr     <= '0;
      end else if (accept) begin
         cnt     <= CW'(WIDTH-1);
         is_div  <= op[1];
         neg_res <= a_neg ^ b_neg;
         neg_rem <= a_neg;
         acc     <= '0;
         if (op[1]) begin
            opnd <= {1'b0, mag_b};
            lsr  <= b_zero ? a : mag_a;
         end else begin
            opnd <= {1'b0, mag_a};
            lsr  <= mag_b;
         end
      end else if (iter) begin
         if (cnt != '0) cnt <= cnt - CW'(1);
         acc <= is_div ? div_acc : mul_acc;
         lsr <= is_div ? div_lsr : mul_lsr;
      end
   end

   // HI/LO result registers and done pulse
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load_res) begin
            hi       <= res_hi;
            lo       <= res_lo;
            div_zero <= 1'b0;
            done     <= 1'b1;
         end else if (load_zdiv) begin
            hi       <= lsr;
            lo       <= '1;
            div_zero <= 1'b1;
            done     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus random ops against
// an arithmetic reference model.
module tb_mdu_iter;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         clear = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(W)) dut (
      .clk      (clk),
      .clear    (clear),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // returns {div_zero, hi, lo}
   function automatic logic [32:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
      int sx, sy, q, r;
      logic [31:0] p;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (o == 2'b00) begin
         p = {16'h0, x} * {16'h0, y};
         return {1'b0, p};
      end else if (o == 2'b01) begin
         p = 32'(sx * sy);
         return {1'b0, p};
      end else if (y == 16'h0) begin
         return {1'b1, x, 16'hFFFF};
      end else if (o == 2'b10) begin
         return {1'b0, x % y, x / y};
      end else begin
         q = sx / sy;
         r = sx % sy;
         return {1'b0, r[15:0], q[15:0]};
      end
   endfunction

   task automatic launch(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
   endtask

   // Called at the negedge where start was raised; follows the op to completion.
   task automatic finish_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                            input int repulse_k, input bit chain,
                            input logic [1:0] o2, input logic [15:0] x2, input logic [15:0] y2);
      logic [32:0] e;
      int k, lat;
      e   = model(o, x, y);
      lat = (o[1] && y == 16'h0) ? 1 : W + 1;
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      chk("busy_after_start", {31'b0, busy}, 32'd1);
      chk("done_low_after_start", {31'b0, done}, 32'd0);
      k = 0;
      while (!done && k < 40) begin
         if (k == repulse_k) begin
            start = 1'b1;
            op = 2'($urandom);
            a  = 16'($urandom);
            b  = 16'($urandom);
         end else if (k == repulse_k + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
         if (!done) chk("busy_during_op", {31'b0, busy}, 32'd1);
      end
      start = 1'b0;
      chk("latency", k, lat);
      chk("hi", {16'h0, hi}, {16'h0, e[31:16]});
      chk("lo", {16'h0, lo}, {16'h0, e[15:0]});
      chk("div_zero", {31'b0, div_zero}, {31'b0, e[32]});
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      if (chain) begin
         launch(o2, x2, y2);
      end else begin
         @(negedge clk);
         chk("done_pulse_width", {31'b0, done}, 32'd0);
         chk("hi_hold", {16'h0, hi}, {16'h0, e[31:16]});
         chk("lo_hold", {16'h0, lo}, {16'h0, e[15:0]});
      end
   endtask

   task automatic run(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
      @(negedge clk);
      launch(o, x, y);
      finish_op(o, x, y, -10, 1'b0, 2'b00, 16'h0, 16'h0);
   endtask

   initial begin
      int seen;
      logic [1:0]  ro;
      logic [15:0] ra, rb;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
      chk("rst_hi", {16'h0, hi}, 32'd0);
      chk("rst_lo", {16'h0, lo}, 32'd0);
      clear = 1'b1;

      // directed arithmetic
      run(2'b00, 16'hFFFF, 16'hFFFF);
      run(2'b01, 16'hFFFE, 16'h0003);
      run(2'b01, 16'h8000, 16'h8000);
      run(2'b10, 16'd100, 16'd7);
      run(2'b11, 16'hFFF9, 16'h0002);
      run(2'b11, 16'h8000, 16'hFFFF);
      run(2'b11, 16'h1234, 16'h0000);
      run(2'b00, 16'h0002, 16'h0003);
      run(2'b10, 16'h0005, 16'h0000);
      run(2'b11, 16'h0007, 16'hFFFE);

      // start re-pulsed at E5 is ignored
      @(negedge clk);
      launch(2'b00, 16'h1357, 16'h2468);
      finish_op(2'b00, 16'h1357, 16'h2468, 4, 1'b0, 2'b00, 16'h0, 16'h0);

      // start held in the done cycle launches a second op
      @(negedge clk);
      launch(2'b01, 16'hFF00, 16'h0102);
      finish_op(2'b01, 16'hFF00, 16'h0102, -10, 1'b1, 2'b11, 16'h8001, 16'h0003);
      finish_op(2'b11, 16'h8001, 16'h0003, -10, 1'b0, 2'b00, 16'h0, 16'h0);

      // clear mid-CALC aborts the op
      @(negedge clk);
      launch(2'b00, 16'h1234, 16'h5678);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      clear = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_hi", {16'h0, hi}, 32'd0);
      chk("abort_lo", {16'h0, lo}, 32'd0);
      chk("abort_div_zero", {31'b0, div_zero}, 32'd0);
      @(negedge clk);
      clear = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("no_done_after_abort", seen, 0);
      run(2'b10, 16'hBEEF, 16'h0123);

      // random operations
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = 16'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         if ($urandom_range(0, 5) == 0) ra = 16'h8000;
         if ($urandom_range(0, 5) == 0) rb = 16'hFFFF;
         run(ro, ra, rb);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
